// File: rtl/float_pkg.sv
// Shared definitions for the float ALU path: field widths, exponent bias,
// field positions and the sequential subtractor state encoding.
package float_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int BIAS     = 127;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int MANT_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } subf_state_t;

endpackage

// File: rtl/subf_seq.sv
// Multi-cycle single-precision subtractor s = a - b, truncating, one shift per cycle.
// Optional zero/flush/infinity handling is enabled by defining SUBF_SPECIAL_EN.
module subf_seq #(
  parameter int EXP_W  = float_pkg::EXP_W,
  parameter int MANT_W = float_pkg::MANT_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   a,
  input  logic [EXP_W+MANT_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   s,
  output logic [2:0]              dbg_state
);
  import float_pkg::*;

  // Handshake: a transfer happens on any rising edge where valid && ready are
  // both high; the producer holds its data until then, and in_ready is high
  // only in IDLE so at most one operation is in flight.

  localparam int MW = MANT_W + 1;   // mantissa with the implicit one

  subf_state_t              state;
  logic                     sa, sb, rs;
  logic [EXP_W-1:0]         ea, eb, re;
  logic [MW-1:0]            ma, mb;
  logic [MW:0]              rm;

  logic [EXP_W-1:0]         exp_inc;
  logic                     norm_done;
  logic [EXP_W+MANT_W:0]    norm_s;

  assign dbg_state = state;

  // Normalisation decision for the current NORM cycle and the value s takes
  // if this cycle finishes the operation.
  always_comb begin
    exp_inc   = re + 1'b1;
    norm_done = 1'b1;
    norm_s    = {rs, re, rm[MANT_W-1:0]};
    if (rm[MW]) begin
      norm_s = {rs, exp_inc, rm[MANT_W:1]};
`ifdef SUBF_SPECIAL_EN
      if (exp_inc == {EXP_W{1'b1}})
        norm_s = {rs, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
`endif
    end else if (rm == '0) begin
      norm_s = '0;
    end else if (!rm[MANT_W]) begin
`ifdef SUBF_SPECIAL_EN
      if (re <= EXP_W'(1))
        norm_s = '0;
      else
        norm_done = 1'b0;
`else
      norm_done = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      rs        <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      re        <= '0;
      ma        <= '0;
      mb        <= '0;
      rm        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa       <= a[EXP_W+MANT_W];
            sb       <= ~b[EXP_W+MANT_W];
            ea       <= a[MANT_W +: EXP_W];
            eb       <= b[MANT_W +: EXP_W];
`ifdef SUBF_SPECIAL_EN
            ma       <= (a[MANT_W +: EXP_W] == '0) ? '0 : {1'b1, a[MANT_W-1:0]};
            mb       <= (b[MANT_W +: EXP_W] == '0) ? '0 : {1'b1, b[MANT_W-1:0]};
`else
            ma       <= {1'b1, a[MANT_W-1:0]};
            mb       <= {1'b1, b[MANT_W-1:0]};
`endif
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          // A mantissa shifted to zero ends alignment early, capping it at MW shifts.
          if (ea == eb) begin
            state <= ADD;
          end else if (ea < eb) begin
            if (ma == '0) state <= ADD;
            else begin
              ma <= ma >> 1;
              ea <= ea + 1'b1;
            end
          end else begin
            if (mb == '0) state <= ADD;
            else begin
              mb <= mb >> 1;
              eb <= eb + 1'b1;
            end
          end
        end
        ADD: begin
          re    <= (ea > eb) ? ea : eb;
          state <= NORM;
          if (sa == sb) begin
            rm <= {1'b0, ma} + {1'b0, mb};
            rs <= sa;
          end else if (ma == mb) begin
            rm <= '0;
            rs <= 1'b0;
            re <= '0;
          end else if (ma > mb) begin
            rm <= {1'b0, ma - mb};
            rs <= sa;
          end else begin
            rm <= {1'b0, mb - ma};
            rs <= sb;
          end
        end
        NORM: begin
          if (norm_done) begin
            s         <= norm_s;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rm <= rm << 1;
            re <= re - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subf_seq.sv
// Bench for subf_seq: directed vectors with exact latency, backpressure,
// mid-operation reset and randomised operands against a reference model.
module tb_subf_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] s;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  subf_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: full-precision signed sum of the aligned (truncated) mantissas.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    int ex, ey, mx, my, d, sh, e, vx, vy, v, mag, n;
    logic       sg;
    logic [7:0] e8;
    logic [31:0] mg;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = 32'h0080_0000 | int'(x[22:0]);
    my = 32'h0080_0000 | int'(y[22:0]);
    d  = (ex >= ey) ? ex - ey : ey - ex;
    sh = (d > 24) ? 24 : d;
    if (ex >= ey) begin e = ex; my = my >> sh; end
    else begin e = ey; mx = mx >> sh; end
    vx = x[31] ? -mx : mx;
    vy = y[31] ? my : -my;
    v  = vx + vy;
    n  = 0;
    if (v == 0) begin
      r = 32'h0;
    end else begin
      sg  = (v < 0);
      mag = sg ? -v : v;
      if (mag >= 32'h0100_0000) begin
        mag = mag >> 1;
        e   = e + 1;
      end else begin
        while (mag < 32'h0080_0000) begin
          mag = mag << 1;
          e   = e - 1;
          n++;
        end
      end
      e8 = e[7:0];
      mg = mag;
      r  = {sg, e8, mg[22:0]};
    end
    lat = sh + 1 + 1 + n + 1;
  endfunction

  task automatic send(input logic [31:0] va, input logic [31:0] vb);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_in_ready got=%b want=1", in_ready);
    end
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic receive(input string name);
    int          cyc;
    logic [31:0] es;
    int          el;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    es = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout out_valid=%b after %0d cycles", name, out_valid, cyc);
    end
    checks++;
    if (s !== es) begin
      failures++;
      $display("FAIL %s_s got=%h want=%h", name, s, es);
    end
    checks++;
    if (cyc != el) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", name, cyc, el);
    end
    if (out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_handshake in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 32'h0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset in_ready=%b out_valid=%b s=%h state=%0d want 1/0/0/0",
               in_ready, out_valid, s, dbg_state);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [31:0] va[5] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    logic [31:0] vb[5] = '{32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h3FC0_0000, 32'h3080_0000};
    logic [31:0] vs[5] = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 32'hBF00_0000, 32'h3F80_0000};
    int          vl[5] = '{4, 3, 3, 4, 27};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vs[i]);
      lat_q.push_back(vl[i]);
      send(va[i], vb[i]);
      receive($sformatf("vec%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] es;
    out_ready = 1'b0;
    exp_q.push_back(32'h4000_0000);
    lat_q.push_back(4);
    es = 32'h4000_0000;
    send(32'h4040_0000, 32'h3F80_0000);
    receive("bp");
    a = 32'h4120_0000;
    b = 32'h3F80_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || s !== es || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d out_valid=%b s=%h in_ready=%b want 1/%h/0",
                 i, out_valid, s, in_ready, es);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h3080_0000);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 32'h0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid in_ready=%b out_valid=%b s=%h state=%0d want 1/0/0/0",
               in_ready, out_valid, s, dbg_state);
    end
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_discard stale out_valid cycles got=%0d want=0", seen);
    end
    exp_q.push_back(32'hBF00_0000);
    lat_q.push_back(4);
    send(32'h3F80_0000, 32'h3FC0_0000);
    receive("after_reset");
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, rs;
    logic [7:0]  e1, e2;
    int          rl;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      e1 = 8'($urandom_range(110, 140));
      e2 = (i % 4 == 0) ? e1 : 8'($urandom_range(110, 140));
      ra = {1'($urandom_range(0, 1)), e1, 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), e2, 23'($urandom)};
      model(ra, rb, rs, rl);
      exp_q.push_back(rs);
      lat_q.push_back(rl);
      send(ra, rb);
      receive($sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
